// File: rtl/userio_joy_serial.sv
// userio_joy_serial: 74HC165-chain joystick reader with whole-scan debouncing.
// Define JOY_AUTOFIRE_EN to add the autofire_mask port and AUTOFIRE_SCANS parameter.
module userio_joy_serial #(
   parameter int PLAYERS        = 2,
   parameter int BITS           = 12,
   parameter int CLK_DIV        = 50,
   parameter int DEBOUNCE_SCANS = 2,
`ifdef JOY_AUTOFIRE_EN
   parameter int AUTOFIRE_SCANS = 4,
`endif
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   output logic                      joy_clk,
   output logic                      joy_load,
   input  logic                      joy_data,
`ifdef JOY_AUTOFIRE_EN
   input  logic [BITS-1:0]           autofire_mask,
`endif
   output logic [PLAYERS*BITS-1:0]   joystick,
   output logic                      scan_done,
   output logic                      changed
);

   localparam int N = PLAYERS * BITS;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int IDX_W = $clog2(N);
   localparam logic [2:0] STABLE_MAX = 3'(DEBOUNCE_SCANS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] bit_q, bit_d;
   logic [2:0]       stable_q, stable_d, stable_n;
   logic [N-1:0]     raw_q, raw_d;
   logic [N-1:0]     prev_q, prev_d;
   logic [N-1:0]     joystick_q, joystick_d;
   logic             joy_clk_q, joy_clk_d;
   logic             joy_load_q, joy_load_d;
   logic             scan_done_q, scan_done_d;
   logic             changed_q, changed_d;
   logic             tick;
   logic             update;

`ifdef JOY_AUTOFIRE_EN
   localparam int AF_W = (AUTOFIRE_SCANS > 1) ? $clog2(AUTOFIRE_SCANS) : 1;

   logic [N-1:0]    deb_q, deb_d, new_deb, full_mask;
   logic [AF_W-1:0] af_cnt_q [N];
   logic [AF_W-1:0] af_cnt_d [N];

   assign full_mask = {PLAYERS{autofire_mask}};
`endif

   always_comb begin
      tick        = (div_q == DIV_W'(CLK_DIV - 1));
      div_d       = (!enable || tick) ? '0 : div_q + 1'b1;
      state_d     = state_q;
      bit_d       = bit_q;
      stable_d    = stable_q;
      stable_n    = stable_q;
      raw_d       = raw_q;
      prev_d      = prev_q;
      joystick_d  = joystick_q;
      scan_done_d = 1'b0;
      changed_d   = 1'b0;
      update      = 1'b0;
`ifdef JOY_AUTOFIRE_EN
      deb_d   = deb_q;
      new_deb = deb_q;
      for (int j = 0; j < N; j++) af_cnt_d[j] = af_cnt_q[j];
`endif

      if (!enable) begin
         // Parking also clears the stable count so a re-enabled scan debounces afresh
         state_d  = IDLE;
         bit_d    = '0;
         stable_d = '0;
      end else if (tick) begin
         case (state_q)
            IDLE:     state_d = LOAD;
            LOAD: begin
               state_d = SHIFT_LO;
               bit_d   = '0;
            end
            SHIFT_LO: begin
               raw_d[bit_q] = joy_data ^ ACTIVE_LOW;
               state_d      = SHIFT_HI;
            end
            SHIFT_HI: begin
               if (bit_q != IDX_W'(N - 1)) begin
                  bit_d   = bit_q + 1'b1;
                  state_d = SHIFT_LO;
               end else begin
                  // The whole scan is evaluated here so the strobes land on COMMIT's first clk
                  state_d     = COMMIT;
                  bit_d       = '0;
                  stable_n    = (raw_q != prev_q) ? 3'd0 :
                                (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 3'd1;
                  stable_d    = stable_n;
                  prev_d      = raw_q;
                  scan_done_d = 1'b1;
                  update      = (stable_n == STABLE_MAX);
`ifdef JOY_AUTOFIRE_EN
                  if (update) new_deb = raw_q;
                  deb_d = new_deb;
                  for (int j = 0; j < N; j++) begin
                     if (!full_mask[j]) begin
                        joystick_d[j] = new_deb[j];
                     end else if (!new_deb[j]) begin
                        joystick_d[j] = 1'b0;
                        af_cnt_d[j]   = '0;
                     end else if (!deb_q[j]) begin
                        joystick_d[j] = 1'b1;
                        af_cnt_d[j]   = '0;
                     end else if (af_cnt_q[j] == AF_W'(AUTOFIRE_SCANS - 1)) begin
                        joystick_d[j] = ~joystick_q[j];
                        af_cnt_d[j]   = '0;
                     end else begin
                        af_cnt_d[j] = af_cnt_q[j] + 1'b1;
                     end
                  end
                  changed_d = (joystick_d != joystick_q);
`else
                  if (update && (raw_q != joystick_q)) begin
                     joystick_d = raw_q;
                     changed_d  = 1'b1;
                  end
`endif
               end
            end
            COMMIT:   state_d = LOAD;
            default:  state_d = IDLE;
         endcase
      end

      joy_clk_d  = (state_d == SHIFT_HI);
      joy_load_d = (state_d != LOAD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         stable_q    <= '0;
         raw_q       <= '0;
         prev_q      <= '0;
         joystick_q  <= '0;
         joy_clk_q   <= 1'b0;
         joy_load_q  <= 1'b1;
         scan_done_q <= 1'b0;
         changed_q   <= 1'b0;
`ifdef JOY_AUTOFIRE_EN
         deb_q <= '0;
         for (int j = 0; j < N; j++) af_cnt_q[j] <= '0;
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         stable_q    <= stable_d;
         raw_q       <= raw_d;
         prev_q      <= prev_d;
         joystick_q  <= joystick_d;
         joy_clk_q   <= joy_clk_d;
         joy_load_q  <= joy_load_d;
         scan_done_q <= scan_done_d;
         changed_q   <= changed_d;
`ifdef JOY_AUTOFIRE_EN
         deb_q <= deb_d;
         for (int j = 0; j < N; j++) af_cnt_q[j] <= af_cnt_d[j];
`endif
      end
   end

   assign joy_clk   = joy_clk_q;
   assign joy_load  = joy_load_q;
   assign joystick  = joystick_q;
   assign scan_done = scan_done_q;
   assign changed   = changed_q;

endmodule
